issue_select: RTL and testbench

Issue-select stage directly downstream of the reservation station (RS). Each cycle it examines the RS `ready` vector and `RS_OUT` entries and picks up to two entries with round-robin priority. The pick respects the single-multiplier limit and the two-port CDB writeback budget. It returns a one-hot `free` mask to the RS and registers the chosen entries into the IS/EX pipeline register that feeds the functional units.

---
 rtl/issue_select_if.sv | 41 ++++
 rtl/issue_select.sv | 103 ++++++++++
 tb/tb_issue_select.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/issue_select_if.sv
// ============================================================================
// issue_select_if : RS <-> issue-select packet type and handshake bundle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

`ifndef RS_SIZE
`define RS_SIZE 16
`endif

package issue_select_pkg;
    typedef enum logic [1:0] {
        FUNC_ALU  = 2'd0,
        FUNC_MULT = 2'd1,
        FUNC_BR   = 2'd2,
        FUNC_MEM  = 2'd3
    } func_unit_t;

    typedef struct packed {
        logic [15:0] inst_id;
        logic [4:0]  dest_tag;
        func_unit_t  func_unit;
    } RS_IS_PACKET;
endpackage

interface issue_select_if #(
    parameter int RS_SIZE = `RS_SIZE
);
    import issue_select_pkg::*;

    RS_IS_PACKET [RS_SIZE-1:0] rs_in;
    logic        [RS_SIZE-1:0] ready;
    logic        [RS_SIZE-1:0] free;
    RS_IS_PACKET [1:0]         is_packet;
    logic        [1:0]         is_valid;

    modport master (output rs_in, ready, input free, is_packet, is_valid);
    modport slave  (input rs_in, ready, output free, is_packet, is_valid);
endinterface

`default_nettype wire

// File: rtl/issue_select.sv
// ============================================================================
// issue_select : dual-issue round-robin selector with mult/CDB budgeting
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module issue_select
    import issue_select_pkg::*;
#(
    parameter int RS_SIZE  = `RS_SIZE,
    parameter int MULT_LAT = 4
) (
    input  wire logic           clock,
    input  wire logic           reset_n,
    input  wire logic           enable,
    input  wire logic           squash_signal_in,
    issue_select_if.slave       rs
);
    localparam int PTR_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int WB_W  = MULT_LAT - 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [WB_W-1:0]  mult_wb;

    logic [RS_SIZE-1:0] free_w;
    logic [1:0]         pick_valid;
    logic [PTR_W-1:0]   pick_idx [2];
    logic               mult_picked;
    logic [PTR_W-1:0]   next_ptr;
    logic [1:0]         npick;
    logic [1:0]         alu_budget;
    logic               mult_ok;
    logic [PTR_W:0]     idx;
    logic [PTR_W-1:0]   cur;
    logic               is_mult;

    // Rotated scan from rr_ptr; ineligible entries are skipped, never blocking.
    always_comb begin
        free_w      = '0;
        pick_valid  = '0;
        pick_idx[0] = '0;
        pick_idx[1] = '0;
        mult_picked = 1'b0;
        next_ptr    = rr_ptr;
        npick       = 2'd0;
        alu_budget  = mult_wb[0] ? 2'd1 : 2'd2;
        mult_ok     = 1'b1;
        idx         = '0;
        cur         = '0;
        is_mult     = 1'b0;
        if (reset_n && enable && !squash_signal_in) begin
            for (int k = 0; k < RS_SIZE; k++) begin
                idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (idx >= (PTR_W+1)'(RS_SIZE))
                    idx = idx - (PTR_W+1)'(RS_SIZE);
                cur     = idx[PTR_W-1:0];
                is_mult = (rs.rs_in[cur].func_unit == FUNC_MULT);
                if (rs.ready[cur] && (npick < 2'd2) &&
                    (is_mult ? mult_ok : (alu_budget != 2'd0))) begin
                    free_w[cur]          = 1'b1;
                    pick_idx[npick[0]]   = cur;
                    pick_valid[npick[0]] = 1'b1;
                    npick                = npick + 2'd1;
                    next_ptr = (cur == PTR_W'(RS_SIZE-1)) ? '0 : cur + 1'b1;
                    if (is_mult) begin
                        mult_ok     = 1'b0;
                        mult_picked = 1'b1;
                    end else begin
                        alu_budget = alu_budget - 2'd1;
                    end
                end
            end
        end
    end

    assign rs.free = free_w;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rs.is_valid  <= '0;
            rs.is_packet <= '0;
            rr_ptr       <= '0;
            mult_wb      <= '0;
        end else if (squash_signal_in) begin
            rs.is_valid <= '0;
            rr_ptr      <= '0;
            mult_wb     <= '0;
        end else begin
            rs.is_valid <= pick_valid;
            for (int l = 0; l < 2; l++) begin
                if (pick_valid[l])
                    rs.is_packet[l] <= rs.rs_in[pick_idx[l]];
            end
            if (|pick_valid)
                rr_ptr <= next_ptr;
            // Bit k: a mult reaches the CDB k+1 cycles from now.
            mult_wb <= (mult_wb >> 1) | (WB_W'(mult_picked) << (MULT_LAT-2));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_issue_select.sv
// ============================================================================
// tb_issue_select : directed self-checking bench for issue_select
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_issue_select;
    import issue_select_pkg::*;

    logic clock;
    logic reset_n;
    logic enable;
    logic squash_signal_in;
    int   tests;
    int   fails;

    issue_select_if #(.RS_SIZE(16)) bus ();

    issue_select #(.RS_SIZE(16), .MULT_LAT(4)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .enable           (enable),
        .squash_signal_in (squash_signal_in),
        .rs               (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_classes(input logic [15:0] mult_mask);
        for (int i = 0; i < 16; i++) begin
            bus.rs_in[i].inst_id   = 16'h0100 + 16'(i);
            bus.rs_in[i].dest_tag  = 5'(i);
            bus.rs_in[i].func_unit = mult_mask[i] ? FUNC_MULT : FUNC_ALU;
        end
    endtask

    task automatic pick(input logic [15:0] r, input logic [15:0] exp_free, input string tag);
        bus.ready = r;
        #1;
        check(tag, 32'(bus.free), 32'(exp_free));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic lanes(input logic [1:0] v, input logic [15:0] id0, input logic [15:0] id1,
                         input string tag);
        check({tag, "_valid"}, 32'(bus.is_valid), 32'(v));
        if (v[0]) check({tag, "_lane0"}, 32'(bus.is_packet[0].inst_id), 32'(id0));
        if (v[1]) check({tag, "_lane1"}, 32'(bus.is_packet[1].inst_id), 32'(id1));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        enable = 1'b1;
        squash_signal_in = 1'b0;
        set_classes(16'h0000);
        bus.ready = 16'hFFFF;
        #1;
        check("reset_free", 32'(bus.free), 32'h0);
        check("reset_valid", 32'(bus.is_valid), 32'h0);
        check("reset_packet", 32'(bus.is_packet), 32'h0);
        #11 reset_n = 1'b1;
        step();

        // Basic pick
        pick(16'h0003, 16'h0003, "basic_free");
        step();
        lanes(2'b11, 16'h0100, 16'h0101, "basic");
        // Wrap from rr_ptr=2
        pick(16'h8005, 16'h8004, "wrap_free");
        step();
        lanes(2'b11, 16'h0102, 16'h010F, "wrap");
        // rr_ptr now 0: entries 0 and 2 (a pointer at 2 would pick 2,3)
        pick(16'h000D, 16'h0005, "rr0_free");
        step();
        lanes(2'b11, 16'h0100, 16'h0102, "rr0");
        // Empty RS, rr_ptr stays 3
        pick(16'h0000, 16'h0000, "empty_free");
        step();
        check("empty_valid", 32'(bus.is_valid), 32'h0);
        pick(16'h0019, 16'h0018, "hold_free");
        step();
        lanes(2'b11, 16'h0103, 16'h0104, "hold");

        // Squash
        squash_signal_in = 1'b1;
        pick(16'hFFFF, 16'h0000, "squash_free");
        step();
        squash_signal_in = 1'b0;
        check("squash_valid", 32'(bus.is_valid), 32'h0);

        // Mult limit, rr_ptr=0
        set_classes(16'h000F);
        pick(16'h000F, 16'h0001, "mult0_free");
        step();
        lanes(2'b01, 16'h0100, 16'h0000, "mult0");
        pick(16'h000E, 16'h0002, "mult1_free");
        step();
        lanes(2'b01, 16'h0101, 16'h0000, "mult1");
        pick(16'h000C, 16'h0004, "mult2_free");
        step();
        lanes(2'b01, 16'h0102, 16'h0000, "mult2");
        pick(16'h0008, 16'h0008, "mult3_free");
        step();
        lanes(2'b01, 16'h0103, 16'h0000, "mult3");

        // CDB conflict: squash clears tracker, then mult at t
        set_classes(16'h0001);
        squash_signal_in = 1'b1;
        pick(16'hFFFF, 16'h0000, "squash2_free");
        step();
        squash_signal_in = 1'b0;
        pick(16'h0001, 16'h0001, "cdb_t_free");
        step();
        pick(16'h0000, 16'h0000, "cdb_t1_free");
        step();
        pick(16'h0000, 16'h0000, "cdb_t2_free");
        step();
        pick(16'h0006, 16'h0002, "cdb_t3_free");
        step();
        lanes(2'b01, 16'h0101, 16'h0000, "cdb_t3");
        pick(16'h0004, 16'h0004, "cdb_t4_free");
        step();

        // Mixed classes from rr_ptr=0
        squash_signal_in = 1'b1;
        pick(16'hFFFF, 16'h0000, "squash3_free");
        step();
        squash_signal_in = 1'b0;
        pick(16'h0007, 16'h0003, "mixed_free");
        step();
        lanes(2'b11, 16'h0100, 16'h0101, "mixed");
        check("mixed_lane0_mult", 32'(bus.is_packet[0].func_unit), 32'(FUNC_MULT));
        // rr_ptr=2: lane0 is entry 2, then wrap to MULT entry 0
        pick(16'h0005, 16'h0005, "mixed_rr_free");
        step();
        lanes(2'b11, 16'h0102, 16'h0100, "mixed_rr");

        // Enable low: nothing issued, rr_ptr held at 1
        enable = 1'b0;
        pick(16'hFFFF, 16'h0000, "disable_free");
        step();
        check("disable_valid", 32'(bus.is_valid), 32'h0);
        enable = 1'b1;
        // mult_wb[0] set here: one ALU (entry 1) plus the MULT (entry 0)
        pick(16'h0003, 16'h0003, "enable_free");
        step();
        lanes(2'b11, 16'h0101, 16'h0100, "enable");

        // Asynchronous reset mid-cycle
        bus.ready = 16'hFFFF;
        #2 reset_n = 1'b0;
        #1;
        check("areset_free", 32'(bus.free), 32'h0);
        check("areset_valid", 32'(bus.is_valid), 32'h0);
        check("areset_packet", 32'(bus.is_packet), 32'h0);
        #2 reset_n = 1'b1;

        // Full RS after reset: MULT 0, MULT 1 blocked, ALU 2
        set_classes(16'h0003);
        pick(16'hFFFF, 16'h0005, "full_free");
        step();
        lanes(2'b11, 16'h0100, 16'h0102, "full");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
